// File: rtl/if_pipe_pkg.sv
// Shared definitions for the IF pipeline stage register: defaults, state encoding, entry layout.
package if_pipe_pkg;

  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned LANES_DEF = 2;

  // Encoding mirrors {main_v, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } pipe_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [LANES_DEF-1:0] lane_mask;
  } entry_def_t;

  function automatic logic [1:0] occupancy(input pipe_state_e s);
    case (s)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator: adds inc every cycle, clamps at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inc,
  output logic [W-1:0] cnt
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, cnt} + {1'b0, inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sum[W]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/if_pipe_reg.sv
// IF stage register with 2-entry skid buffer; in_ready depends only on registered state.
// Optional performance counters enabled by defining IF_PIPE_PERF_EN.
module if_pipe_reg
  import if_pipe_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [LANES-1:0] in_lane_mask,
  input  logic             stall_load,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [LANES-1:0] out_lane_mask
`ifdef IF_PIPE_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [LANES-1:0] lane_mask;
  } entry_t;

  pipe_state_e state_q, state_d;
  entry_t      main_q, skid_q, in_entry;
  logic        acc, dq;
  logic        load_main, load_skid, main_from_skid;

  assign in_entry      = '{pc: in_pc, lane_mask: in_lane_mask};
  assign in_ready      = (state_q != FULL);
  assign out_valid     = (state_q != EMPTY);
  assign out_pc        = main_q.pc;
  assign out_lane_mask = main_q.lane_mask;

  assign acc = in_valid & in_ready;
  assign dq  = out_valid & out_ready & ~stall_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush only retargets state; data enables stay low so payload regs hold.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (acc && dq) begin
            load_main = 1'b1;
          end else if (acc) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (dq) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (dq) begin
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

`ifdef IF_PIPE_PERF_EN
  logic [31:0] stall_inc, flush_inc;
  logic [1:0]  flush_amt;

  always_comb begin
    flush_amt = occupancy(state_q) + {1'b0, acc};
    stall_inc = {31'd0, out_valid & ~(out_ready & ~stall_load)};
    flush_inc = flush ? {30'd0, flush_amt} : '0;
  end

  sat_counter #(.W(32)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (perf_stall_cnt)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_pipe_reg.sv
// Self-checking bench for if_pipe_reg: directed vector table, reset corner, random traffic vs queue model.
module tb_if_pipe_reg;

  logic        clk, rst;
  logic        in_valid, in_ready, stall_load, flush, out_valid, out_ready;
  logic [31:0] in_pc, out_pc;
  logic [1:0]  in_lane_mask, out_lane_mask;
`ifdef IF_PIPE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  if_pipe_reg #(.PC_W(32), .LANES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_lane_mask  (in_lane_mask),
    .stall_load    (stall_load),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_lane_mask (out_lane_mask)
`ifdef IF_PIPE_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mask;
  } bundle_t;

  typedef struct {
    bit          iv;
    logic [31:0] pc;
    logic [1:0]  m;
    bit          st;
    bit          fl;
    bit          ordy;
    bit          eov;
    bit          eir;
    logic [31:0] epc;
    logic [1:0]  em;
  } vec_t;

  bundle_t     mq[$];
  longint      m_stall, m_flush;
  int          checks, errors;
  vec_t        tbl[22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare against the queue model before the edge, then advance the model across it.
  task automatic cycle();
    bit acc, dq;
    int sz;
    bundle_t b;
    @(negedge clk);
    sz = mq.size();
    chk("out_valid", {63'd0, out_valid}, {63'd0, sz > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, sz < 2});
    if (sz > 0) begin
      chk("out_pc", {32'd0, out_pc}, {32'd0, mq[0].pc});
      chk("out_lane_mask", {62'd0, out_lane_mask}, {62'd0, mq[0].mask});
    end
`ifdef IF_PIPE_PERF_EN
    chk("perf_stall_cnt", {32'd0, perf_stall_cnt}, m_stall);
    chk("perf_flush_cnt", {32'd0, perf_flush_cnt}, m_flush);
`endif
    acc = in_valid && (sz < 2);
    dq  = (sz > 0) && out_ready && !stall_load;
    if (sz > 0 && !(out_ready && !stall_load)) m_stall++;
    if (flush) m_flush += sz + int'(acc);
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (dq) void'(mq.pop_front());
      if (acc) begin
        b.pc   = in_pc;
        b.mask = in_lane_mask;
        mq.push_back(b);
      end
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] pc, input logic [1:0] m,
                       input bit st, input bit fl, input bit ordy);
    in_valid     = iv;
    in_pc        = pc;
    in_lane_mask = m;
    stall_load   = st;
    flush        = fl;
    out_ready    = ordy;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_stall = 0;
    m_flush = 0;
    rst = 1'b1;
    drive(0, 32'd0, 2'd0, 0, 0, 0);

    //         iv  pc            m    st fl or  eov eir epc           em
    tbl[0]  = '{1, 32'h1c000000, 2'd3, 0, 0, 1,  1, 1, 32'h1c000000, 2'd3};
    tbl[1]  = '{1, 32'h1c000008, 2'd1, 0, 0, 1,  1, 1, 32'h1c000008, 2'd1};
    tbl[2]  = '{1, 32'h1c000010, 2'd2, 0, 0, 1,  1, 1, 32'h1c000010, 2'd2};
    tbl[3]  = '{0, 32'h0,        2'd0, 0, 0, 1,  0, 1, 32'h1c000010, 2'd2};
    tbl[4]  = '{1, 32'h100,      2'd3, 0, 0, 0,  1, 1, 32'h100,      2'd3};
    tbl[5]  = '{1, 32'h108,      2'd0, 0, 0, 0,  1, 0, 32'h100,      2'd3};
    tbl[6]  = '{0, 32'h0,        2'd0, 0, 0, 1,  1, 1, 32'h108,      2'd0};
    tbl[7]  = '{0, 32'h0,        2'd0, 0, 0, 1,  0, 1, 32'h108,      2'd0};
    tbl[8]  = '{1, 32'h300,      2'd1, 0, 0, 0,  1, 1, 32'h300,      2'd1};
    tbl[9]  = '{1, 32'h308,      2'd2, 0, 0, 0,  1, 0, 32'h300,      2'd1};
    tbl[10] = '{0, 32'h0,        2'd0, 1, 0, 1,  1, 0, 32'h300,      2'd1};
    tbl[11] = '{0, 32'h0,        2'd0, 1, 0, 1,  1, 0, 32'h300,      2'd1};
    tbl[12] = '{0, 32'h0,        2'd0, 0, 0, 1,  1, 1, 32'h308,      2'd2};
    tbl[13] = '{0, 32'h0,        2'd0, 0, 0, 1,  0, 1, 32'h308,      2'd2};
    tbl[14] = '{1, 32'h400,      2'd3, 0, 0, 0,  1, 1, 32'h400,      2'd3};
    tbl[15] = '{1, 32'h408,      2'd1, 0, 0, 0,  1, 0, 32'h400,      2'd3};
    tbl[16] = '{1, 32'h200,      2'd2, 0, 1, 0,  0, 1, 32'h400,      2'd3};
    tbl[17] = '{0, 32'h0,        2'd0, 0, 0, 1,  0, 1, 32'h400,      2'd3};
    tbl[18] = '{1, 32'h500,      2'd2, 0, 0, 0,  1, 1, 32'h500,      2'd2};
    tbl[19] = '{0, 32'h0,        2'd0, 1, 0, 1,  1, 1, 32'h500,      2'd2};
    tbl[20] = '{0, 32'h0,        2'd0, 1, 1, 1,  0, 1, 32'h500,      2'd2};
    tbl[21] = '{0, 32'h0,        2'd0, 0, 0, 1,  0, 1, 32'h500,      2'd2};

    #1;
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].iv, tbl[i].pc, tbl[i].m, tbl[i].st, tbl[i].fl, tbl[i].ordy);
      cycle();
      chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].eov});
      chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].eir});
      chk($sformatf("vec%0d out_pc", i), {32'd0, out_pc}, {32'd0, tbl[i].epc});
      chk($sformatf("vec%0d out_lane_mask", i), {62'd0, out_lane_mask}, {62'd0, tbl[i].em});
    end

    // Async reset with both entries occupied
    drive(1, 32'hA00, 2'd1, 0, 0, 0);
    cycle();
    drive(1, 32'hA08, 2'd2, 0, 0, 0);
    cycle();
    drive(0, 32'd0, 2'd0, 0, 0, 0);
    chk("pre-reset full", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst out_pc", {32'd0, out_pc}, 64'd0);
    chk("midrst out_lane_mask", {62'd0, out_lane_mask}, 64'd0);
`ifdef IF_PIPE_PERF_EN
    chk("midrst perf_stall_cnt", {32'd0, perf_stall_cnt}, 64'd0);
    chk("midrst perf_flush_cnt", {32'd0, perf_flush_cnt}, 64'd0);
`endif
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic checked every cycle against the queue model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0);
      cycle();
    end
    drive(0, 32'd0, 2'd0, 0, 0, 1);
    cycle();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
